// File: rtl/ahb_master_arbiter.sv
// Two-master AHB-Lite arbiter in front of a single shared slave port.
// Bursts and locked sequences are never split; the losing master is stalled through its HREADY.
module ahb_master_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [AW-1:0] m0_haddr_i,
  input  logic          m0_hwrite_i,
  input  logic [2:0]    m0_hsize_i,
  input  logic [2:0]    m0_hburst_i,
  input  logic [3:0]    m0_hprot_i,
  input  logic [1:0]    m0_htrans_i,
  input  logic          m0_hmastlock_i,
  input  logic [DW-1:0] m0_hwdata_i,
  input  logic [AW-1:0] m1_haddr_i,
  input  logic          m1_hwrite_i,
  input  logic [2:0]    m1_hsize_i,
  input  logic [2:0]    m1_hburst_i,
  input  logic [3:0]    m1_hprot_i,
  input  logic [1:0]    m1_htrans_i,
  input  logic          m1_hmastlock_i,
  input  logic [DW-1:0] m1_hwdata_i,
  output logic          m0_hready_o,
  output logic          m0_hresp_o,
  output logic [DW-1:0] m0_hrdata_o,
  output logic          m1_hready_o,
  output logic          m1_hresp_o,
  output logic [DW-1:0] m1_hrdata_o,
  output logic [AW-1:0] s_haddr_o,
  output logic          s_hwrite_o,
  output logic [2:0]    s_hsize_o,
  output logic [2:0]    s_hburst_o,
  output logic [3:0]    s_hprot_o,
  output logic [1:0]    s_htrans_o,
  output logic          s_hmastlock_o,
  output logic [DW-1:0] s_hwdata_o,
  input  logic          s_hready_i,
  input  logic          s_hresp_i,
  input  logic [DW-1:0] s_hrdata_i,
  output logic          grant_o
);

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } htrans_e;

  logic       grant, grant_nxt;
  logic       dp_own, dp_own_nxt;
  logic       dp_vld, dp_vld_nxt;
  logic [3:0] beat_cnt, beat_cnt_nxt;
  logic       last_srv, last_srv_nxt;

  logic       req0, req1;
  logic [3:0] beat_upd;
  logic       hold;
  logic       nonseq_acc;
  logic       rr_last;

  function automatic logic [3:0] burst_beats(input logic [2:0] burst);
    case (burst)
      3'b010, 3'b011: burst_beats = 4'd3;
      3'b100, 3'b101: burst_beats = 4'd7;
      3'b110, 3'b111: burst_beats = 4'd15;
      default:        burst_beats = 4'd0;
    endcase
  endfunction

  assign req0 = m0_htrans_i[1];
  assign req1 = m1_htrans_i[1];

  assign s_haddr_o     = grant ? m1_haddr_i     : m0_haddr_i;
  assign s_hwrite_o    = grant ? m1_hwrite_i    : m0_hwrite_i;
  assign s_hsize_o     = grant ? m1_hsize_i     : m0_hsize_i;
  assign s_hburst_o    = grant ? m1_hburst_i    : m0_hburst_i;
  assign s_hprot_o     = grant ? m1_hprot_i     : m0_hprot_i;
  assign s_htrans_o    = grant ? m1_htrans_i    : m0_htrans_i;
  assign s_hmastlock_o = grant ? m1_hmastlock_i : m0_hmastlock_i;
  assign s_hwdata_o    = dp_own ? m1_hwdata_i   : m0_hwdata_i;

  assign m0_hrdata_o = s_hrdata_i;
  assign m1_hrdata_o = s_hrdata_i;
  assign grant_o     = grant;

  always_comb begin
    m0_hready_o = ~req0;
    m0_hresp_o  = 1'b0;
    if (dp_vld && !dp_own) begin
      m0_hready_o = s_hready_i;
      m0_hresp_o  = s_hresp_i;
    end else if (!grant) begin
      m0_hready_o = s_hready_i;
    end
  end

  always_comb begin
    m1_hready_o = ~req1;
    m1_hresp_o  = 1'b0;
    if (dp_vld && dp_own) begin
      m1_hready_o = s_hready_i;
      m1_hresp_o  = s_hresp_i;
    end else if (grant) begin
      m1_hready_o = s_hready_i;
    end
  end

  // Beat counter value if the current address phase is accepted; BUSY keeps the count.
  always_comb begin
    beat_upd = beat_cnt;
    case (s_htrans_o)
      TR_NONSEQ: beat_upd = burst_beats(s_hburst_o);
      TR_SEQ:    beat_upd = (beat_cnt != 4'd0) ? beat_cnt - 4'd1 : 4'd0;
      TR_IDLE:   beat_upd = 4'd0;
      default:   beat_upd = beat_cnt;
    endcase
  end

  assign hold       = s_hmastlock_o | (beat_upd != 4'd0);
  assign nonseq_acc = s_hready_i && (s_htrans_o == TR_NONSEQ);
  // Round-robin sees the master served on this very cycle, so back-to-back contention alternates.
  assign rr_last    = nonseq_acc ? grant : last_srv;

  always_comb begin
    grant_nxt    = grant;
    dp_own_nxt   = dp_own;
    dp_vld_nxt   = dp_vld;
    beat_cnt_nxt = beat_cnt;
    last_srv_nxt = last_srv;
    if (s_hready_i) begin
      dp_vld_nxt   = s_htrans_o[1];
      dp_own_nxt   = grant;
      beat_cnt_nxt = beat_upd;
      if (nonseq_acc) last_srv_nxt = grant;
      if (!hold) begin
        case ({req1, req0})
          2'b11:   grant_nxt = (FIXED_PRIO != 0) ? 1'b0 : ~rr_last;
          2'b10:   grant_nxt = 1'b1;
          2'b01:   grant_nxt = 1'b0;
          default: grant_nxt = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant    <= 1'b0;
      dp_own   <= 1'b0;
      dp_vld   <= 1'b0;
      beat_cnt <= 4'd0;
      last_srv <= 1'b1;
    end else begin
      grant    <= grant_nxt;
      dp_own   <= dp_own_nxt;
      dp_vld   <= dp_vld_nxt;
      beat_cnt <= beat_cnt_nxt;
      last_srv <= last_srv_nxt;
    end
  end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter: single transfers, round-robin contention,
// fixed bursts, locked sequences, wait states with ERROR, and asynchronous reset.
module tb_ahb_master_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic [AW-1:0] m0_haddr, m1_haddr;
  logic          m0_hwrite, m1_hwrite;
  logic [2:0]    m0_hsize, m1_hsize;
  logic [2:0]    m0_hburst, m1_hburst;
  logic [3:0]    m0_hprot, m1_hprot;
  logic [1:0]    m0_htrans, m1_htrans;
  logic          m0_hmastlock, m1_hmastlock;
  logic [DW-1:0] m0_hwdata, m1_hwdata;
  logic          m0_hready, m0_hresp, m1_hready, m1_hresp;
  logic [DW-1:0] m0_hrdata, m1_hrdata;
  logic [AW-1:0] s_haddr;
  logic          s_hwrite;
  logic [2:0]    s_hsize, s_hburst;
  logic [3:0]    s_hprot;
  logic [1:0]    s_htrans;
  logic          s_hmastlock;
  logic [DW-1:0] s_hwdata;
  logic          s_hready, s_hresp;
  logic [DW-1:0] s_hrdata;
  logic          grant;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ahb_master_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(0)) dut (
    .clk(clk), .resetn(resetn),
    .m0_haddr_i(m0_haddr), .m0_hwrite_i(m0_hwrite), .m0_hsize_i(m0_hsize),
    .m0_hburst_i(m0_hburst), .m0_hprot_i(m0_hprot), .m0_htrans_i(m0_htrans),
    .m0_hmastlock_i(m0_hmastlock), .m0_hwdata_i(m0_hwdata),
    .m1_haddr_i(m1_haddr), .m1_hwrite_i(m1_hwrite), .m1_hsize_i(m1_hsize),
    .m1_hburst_i(m1_hburst), .m1_hprot_i(m1_hprot), .m1_htrans_i(m1_htrans),
    .m1_hmastlock_i(m1_hmastlock), .m1_hwdata_i(m1_hwdata),
    .m0_hready_o(m0_hready), .m0_hresp_o(m0_hresp), .m0_hrdata_o(m0_hrdata),
    .m1_hready_o(m1_hready), .m1_hresp_o(m1_hresp), .m1_hrdata_o(m1_hrdata),
    .s_haddr_o(s_haddr), .s_hwrite_o(s_hwrite), .s_hsize_o(s_hsize),
    .s_hburst_o(s_hburst), .s_hprot_o(s_hprot), .s_htrans_o(s_htrans),
    .s_hmastlock_o(s_hmastlock), .s_hwdata_o(s_hwdata),
    .s_hready_i(s_hready), .s_hresp_i(s_hresp), .s_hrdata_i(s_hrdata),
    .grant_o(grant)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic m0_drv(input logic [1:0] tr, input logic [31:0] a, input logic [2:0] b,
                        input logic w, input logic lk);
    m0_htrans = tr; m0_haddr = a; m0_hburst = b; m0_hwrite = w; m0_hmastlock = lk;
  endtask

  task automatic m1_drv(input logic [1:0] tr, input logic [31:0] a, input logic [2:0] b,
                        input logic w, input logic lk);
    m1_htrans = tr; m1_haddr = a; m1_hburst = b; m1_hwrite = w; m1_hmastlock = lk;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    m0_drv(2'b00, 32'h0, 3'b000, 1'b0, 1'b0);
    m1_drv(2'b00, 32'h0, 3'b000, 1'b0, 1'b0);
    m0_hsize = 3'b010; m1_hsize = 3'b010;
    m0_hprot = 4'b0011; m1_hprot = 4'b0011;
    m0_hwdata = '0; m1_hwdata = '0;
    s_hready = 1'b1; s_hresp = 1'b0; s_hrdata = '0;

    // reset state
    do_reset();
    mid();
    chk("rst_grant", grant, 0);
    chk("rst_dp_vld", dut.dp_vld, 0);
    chk("rst_beat_cnt", dut.beat_cnt, 0);
    chk("rst_m0_hready", m0_hready, 1);
    chk("rst_m1_hready", m1_hready, 1);
    chk("rst_m0_hresp", m0_hresp, 0);
    next_cyc();

    // master 0 SINGLE write
    m0_drv(2'b10, 32'h0000_0100, 3'b000, 1'b1, 1'b0);
    mid();
    chk("wr_addr", s_haddr, 32'h100);
    chk("wr_trans", s_htrans, 2'b10);
    chk("wr_hwrite", s_hwrite, 1);
    chk("wr_grant", grant, 0);
    chk("wr_m1_hready_a", m1_hready, 1);
    next_cyc();
    m0_drv(2'b00, 32'h0, 3'b000, 1'b0, 1'b0);
    m0_hwdata = 32'hDEAD_BEEF;
    mid();
    chk("wr_hwdata", s_hwdata, 32'hDEAD_BEEF);
    chk("wr_m1_hready_d", m1_hready, 1);
    chk("wr_grant_d", grant, 0);
    chk("wr_dp_vld", dut.dp_vld, 1);
    next_cyc();
    m0_hwdata = '0;

    // simultaneous requests after reset alternate 0,1,0,1,...
    do_reset();
    for (int i = 0; i < 8; i++) begin
      m0_drv(2'b10, 32'h1000 + 32'(4 * ((i + 1) / 2)), 3'b000, 1'b0, 1'b0);
      m1_drv(2'b10, 32'h2000 + 32'(4 * (i / 2)), 3'b000, 1'b0, 1'b0);
      s_hrdata = 32'hCAFE_0000 + 32'(i);
      mid();
      chk($sformatf("rr_grant_%0d", i), grant, i % 2);
      chk($sformatf("rr_addr_%0d", i), s_haddr,
          (i % 2 == 0) ? 32'h1000 + 32'(4 * (i / 2)) : 32'h2000 + 32'(4 * (i / 2)));
      if (i == 0) chk("rr_m1_stall", m1_hready, 0);
      if (i == 2) begin
        chk("rr_rdata_m0", m0_hrdata, 32'hCAFE_0002);
        chk("rr_rdata_m1", m1_hrdata, 32'hCAFE_0002);
      end
      next_cyc();
    end
    m0_drv(2'b00, 32'h0, 3'b000, 1'b0, 1'b0);
    m1_drv(2'b00, 32'h0, 3'b000, 1'b0, 1'b0);
    mid();
    chk("rr_after_grant", grant, 0);
    next_cyc();

    // master 1 INCR4 not split by master 0 request on beat 2
    m1_drv(2'b10, 32'h200, 3'b011, 1'b0, 1'b0);
    mid();
    chk("b4_m1_wait", m1_hready, 0);
    next_cyc();
    mid();
    chk("b4_beat1_grant", grant, 1);
    chk("b4_beat1_addr", s_haddr, 32'h200);
    chk("b4_beat1_m1_hready", m1_hready, 1);
    next_cyc();
    for (int b = 1; b < 4; b++) begin
      m1_drv(2'b11, 32'h200 + 32'(4 * b), 3'b011, 1'b0, 1'b0);
      m0_drv(2'b10, 32'h300, 3'b000, 1'b0, 1'b0);
      mid();
      chk($sformatf("b4_grant_beat%0d", b + 1), grant, 1);
      chk($sformatf("b4_m0_stall_beat%0d", b + 1), m0_hready, 0);
      chk($sformatf("b4_cnt_beat%0d", b + 1), dut.beat_cnt, 4 - b);
      chk($sformatf("b4_addr_beat%0d", b + 1), s_haddr, 32'h200 + 32'(4 * b));
      next_cyc();
    end
    m1_drv(2'b00, 32'h0, 3'b000, 1'b0, 1'b0);
    mid();
    chk("b4_after_grant", grant, 0);
    chk("b4_after_m0_hready", m0_hready, 1);
    chk("b4_after_addr", s_haddr, 32'h300);
    chk("b4_after_cnt", dut.beat_cnt, 0);
    next_cyc();
    m0_drv(2'b00, 32'h0, 3'b000, 1'b0, 1'b0);
    next_cyc();

    // master 0 locked sequence of 3 SINGLEs while master 1 requests
    m1_drv(2'b10, 32'h500, 3'b000, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      m0_drv(2'b10, 32'h400 + 32'(4 * k), 3'b000, 1'b1, 1'b1);
      mid();
      chk($sformatf("lk_grant_%0d", k), grant, 0);
      chk($sformatf("lk_m1_stall_%0d", k), m1_hready, 0);
      chk($sformatf("lk_lock_%0d", k), s_hmastlock, 1);
      next_cyc();
    end
    m0_drv(2'b00, 32'h0, 3'b000, 1'b0, 1'b0);
    mid();
    chk("lk_release_grant", grant, 0);
    chk("lk_release_lock", s_hmastlock, 0);
    next_cyc();
    mid();
    chk("lk_switch_grant", grant, 1);
    chk("lk_switch_addr", s_haddr, 32'h500);
    chk("lk_switch_m1_hready", m1_hready, 1);
    next_cyc();
    m1_drv(2'b00, 32'h0, 3'b000, 1'b0, 1'b0);
    next_cyc();
    mid();
    chk("lk_park", grant, 0);
    next_cyc();

    // master 1 read with 2 wait states then a two-cycle ERROR
    m1_drv(2'b10, 32'h600, 3'b000, 1'b0, 1'b0);
    next_cyc();
    mid();
    chk("er_grant", grant, 1);
    chk("er_addr", s_haddr, 32'h600);
    next_cyc();
    m1_drv(2'b00, 32'h0, 3'b000, 1'b0, 1'b0);
    m0_drv(2'b10, 32'h700, 3'b000, 1'b0, 1'b0);
    s_hready = 1'b0; s_hresp = 1'b0;
    for (int w = 0; w < 2; w++) begin
      mid();
      chk($sformatf("er_wait_m1_hready_%0d", w), m1_hready, 0);
      chk($sformatf("er_wait_m1_hresp_%0d", w), m1_hresp, 0);
      chk($sformatf("er_wait_grant_%0d", w), grant, 1);
      chk($sformatf("er_wait_cnt_%0d", w), dut.beat_cnt, 0);
      chk($sformatf("er_wait_m0_stall_%0d", w), m0_hready, 0);
      next_cyc();
    end
    s_hresp = 1'b1;
    mid();
    chk("er1_m1_hresp", m1_hresp, 1);
    chk("er1_m1_hready", m1_hready, 0);
    chk("er1_m0_hresp", m0_hresp, 0);
    chk("er1_grant", grant, 1);
    next_cyc();
    s_hready = 1'b1;
    s_hrdata = 32'h1234_5678;
    mid();
    chk("er2_m1_hresp", m1_hresp, 1);
    chk("er2_m1_hready", m1_hready, 1);
    chk("er2_m0_hresp", m0_hresp, 0);
    chk("er2_rdata_m1", m1_hrdata, 32'h1234_5678);
    next_cyc();
    s_hresp = 1'b0;
    mid();
    chk("er_post_grant", grant, 0);
    chk("er_post_addr", s_haddr, 32'h700);
    chk("er_post_m0_hready", m0_hready, 1);
    chk("er_post_m1_hresp", m1_hresp, 0);
    next_cyc();
    m0_drv(2'b00, 32'h0, 3'b000, 1'b0, 1'b0);
    next_cyc();

    // asynchronous reset in the middle of a master 1 INCR8
    m1_drv(2'b10, 32'h800, 3'b101, 1'b0, 1'b0);
    next_cyc();
    mid();
    chk("r8_grant", grant, 1);
    next_cyc();
    m1_drv(2'b11, 32'h804, 3'b101, 1'b0, 1'b0);
    mid();
    chk("r8_cnt7", dut.beat_cnt, 7);
    next_cyc();
    m1_drv(2'b11, 32'h808, 3'b101, 1'b0, 1'b0);
    mid();
    chk("r8_cnt6", dut.beat_cnt, 6);
    #1;
    resetn = 1'b0;
    #1;
    chk("r8_rst_grant", grant, 0);
    chk("r8_rst_dp_vld", dut.dp_vld, 0);
    chk("r8_rst_cnt", dut.beat_cnt, 0);
    chk("r8_rst_addr", s_haddr, 32'h0);
    m1_drv(2'b00, 32'h0, 3'b000, 1'b0, 1'b0);
    m0_drv(2'b10, 32'h900, 3'b000, 1'b0, 1'b0);
    next_cyc();
    resetn = 1'b1;
    mid();
    chk("r8_post_grant", grant, 0);
    chk("r8_post_m0_hready", m0_hready, 1);
    chk("r8_post_addr", s_haddr, 32'h900);
    next_cyc();
    m0_drv(2'b00, 32'h0, 3'b000, 1'b0, 1'b0);
    mid();
    chk("r8_post_dp_vld", dut.dp_vld, 1);
    next_cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
